// File: rtl/tribus_arbiter.sv
// Round-robin owner of a keeper-held tri-state bus: TURN (drivers off) between owners, bus sampled into Q.
// Latency: REQ in IDLE -> GNT +1, OE +2, Q/QV +3. The owner holds the bus while REQ stays high.
// Under TRIBUS_BURST_LIMIT_EN, an owner is preempted after BURST drive cycles if another master is waiting.
module tribus_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int BURST = 8
) (
  input  logic           CK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] DIN,
  output logic [N-1:0]   GNT,
  output logic [N-1:0]   OE,
  inout  wire  [W-1:0]   BUS,
  output logic [W-1:0]   Q,
  output logic           QV
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("tribus_arbiter: N must be in 2..8");
  end
  if (BURST < 1 || BURST > 32) begin : g_bad_burst
    $error("tribus_arbiter: BURST must be in 1..32");
  end

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_DRIVE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  oe_q, oe_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [W-1:0]  q_q;
  logic          qv_q;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic [IW-1:0] win_nxt;
  logic [N-1:0]  win_oh;
  logic          others;
  logic          preempt;
  logic [W-1:0]  bus_drv;

  // First requester at or after the rr pointer, wrapping modulo N.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(rr_q) + k) % N);
      if (!win_vld && REQ[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_nxt = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
  assign win_oh  = N'(1) << win_idx;
  assign others  = |(REQ & ~gnt_q);
  assign bus_drv = DIN[own_q*W +: W];

`ifdef TRIBUS_BURST_LIMIT_EN
  logic [4:0] burst_q, burst_d;

  always_comb begin
    burst_d = burst_q;
    if (state_q == S_TURN) begin
      burst_d = '0;
    end else if (state_q == S_DRIVE && burst_q != 5'h1f) begin
      burst_d = burst_q + 5'd1;
    end
  end

  assign preempt = (burst_q == 5'(BURST - 1)) && others;

  always_ff @(posedge CK) begin
    if (RST) burst_q <= '0;
    else     burst_q <= burst_d;
  end
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    oe_d    = oe_q;
    own_d   = own_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          gnt_d   = win_oh;
          own_d   = win_idx;
          rr_d    = win_nxt;
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        oe_d    = gnt_q;
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (REQ[own_q] && !preempt) begin
          state_d = S_DRIVE;
        end else if (others) begin
          // Owner sorts last from rr_q, so a pending peer always wins here.
          gnt_d   = win_oh;
          own_d   = win_idx;
          rr_d    = win_nxt;
          oe_d    = '0;
          state_d = S_TURN;
        end else begin
          gnt_d   = '0;
          oe_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        oe_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      oe_q    <= '0;
      own_q   <= '0;
      rr_q    <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      oe_q    <= oe_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      if (|oe_q) begin
        q_q  <= bus_drv;
        qv_q <= 1'b1;
      end else begin
        qv_q <= 1'b0;
      end
    end
  end

  // Released bus keeps its last value through the external keeper.
  assign BUS = (|oe_q) ? bus_drv : {W{1'bz}};
  assign GNT = gnt_q;
  assign OE  = oe_q;
  assign Q   = q_q;
  assign QV  = qv_q;

endmodule
